// File: rtl/leaf_out_packetizer.sv
// Credit-checked packetizer: turns each accepted HLS output word into one BFT packet
// addressed to a configured leaf/port, with a wrapping slot address and credit flow control.
module leaf_out_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic [PAYLOAD_BITS-1:0]  din,
  input  logic                     din_vld,
  output logic                     din_ack,
  input  logic                     cfg_wr,
  input  logic [NUM_LEAF_BITS-1:0] cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_port,
  input  logic                     credit_ret,
  output logic [PACKET_BITS-1:0]   pkt_out,
  input  logic                     pkt_ready,
  output logic [NUM_ADDR_BITS:0]   credit,
  output logic                     err_credit
);

  localparam int CW = NUM_ADDR_BITS + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(1 << NUM_ADDR_BITS);
  localparam logic [CW:0] FREE_C  = (CW+1)'(FREESPACE_UPDATE_SIZE);
  localparam logic [NUM_ADDR_BITS-1:0] SEQ_ONE = {{(NUM_ADDR_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    UNCFG    = 2'd0,
    RUN      = 2'd1,
    NOCREDIT = 2'd2
  } state_t;

  state_t                   state_r;
  logic [NUM_LEAF_BITS-1:0] leaf_r;
  logic [NUM_PORT_BITS-1:0] port_r;
  logic [NUM_ADDR_BITS-1:0] seq_r;
  logic [CW-1:0]            credit_r;
  logic                     err_r;
  logic [PACKET_BITS-1:0]   pkt_r;

  logic                     accept_s;
  logic [CW:0]              credit_sum_s;
  logic [CW-1:0]            credit_next_s;
  logic                     overflow_s;

  // Accept decision and the net credit after this cycle's accept and return
  always_comb begin
    accept_s      = din_vld & (state_r == RUN) & ~cfg_wr & (~pkt_r[PACKET_BITS-1] | pkt_ready);
    credit_sum_s  = {1'b0, credit_r} + (credit_ret ? FREE_C : {(CW+1){1'b0}})
                    - {{CW{1'b0}}, accept_s};
    credit_next_s = credit_r;
    overflow_s    = 1'b0;
    if (credit_sum_s > DEPTH_C) begin
      credit_next_s = DEPTH_C[CW-1:0];
      overflow_s    = 1'b1;
    end else begin
      credit_next_s = credit_sum_s[CW-1:0];
      overflow_s    = 1'b0;
    end
  end

  // Control FSM, destination/sequence/credit registers and the one-deep packet register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_r  <= UNCFG;
      leaf_r   <= {NUM_LEAF_BITS{1'b0}};
      port_r   <= {NUM_PORT_BITS{1'b0}};
      seq_r    <= {NUM_ADDR_BITS{1'b0}};
      credit_r <= DEPTH_C[CW-1:0];
      err_r    <= 1'b0;
      pkt_r    <= {PACKET_BITS{1'b0}};
    end else if (cfg_wr) begin
      // A reconfigure never accepts, but a packet already in flight still drains
      state_r  <= RUN;
      leaf_r   <= cfg_leaf;
      port_r   <= cfg_port;
      seq_r    <= {NUM_ADDR_BITS{1'b0}};
      credit_r <= DEPTH_C[CW-1:0];
      if (pkt_ready) begin
        pkt_r[PACKET_BITS-1] <= 1'b0;
      end
    end else begin
      if (accept_s) begin
        pkt_r <= {1'b1, leaf_r, port_r, seq_r, din};
        seq_r <= seq_r + SEQ_ONE;
      end else if (pkt_ready) begin
        pkt_r[PACKET_BITS-1] <= 1'b0;
      end
      credit_r <= credit_next_s;
      if (overflow_s) begin
        err_r <= 1'b1;
      end
      case (state_r)
        UNCFG:         state_r <= UNCFG;
        RUN, NOCREDIT: state_r <= (credit_next_s == {CW{1'b0}}) ? NOCREDIT : RUN;
        default:       state_r <= UNCFG;
      endcase
    end
  end

  assign din_ack    = accept_s;
  assign pkt_out    = pkt_r;
  assign credit     = credit_r;
  assign err_credit = err_r;

endmodule
